// File: rtl/saikoro_pkg.sv
// Shared types and constants for the saikoro roll sequencer: FSM states,
// legal face range and the jitter LFSR polynomial/seed.
package saikoro_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPIN,
    SLOW,
    SETTLE,
    DONE
  } state_t;

  localparam logic [2:0] FACE_MIN = 3'd1;
  localparam logic [2:0] FACE_MAX = 3'd6;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting left with feedback into bit 0.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  function automatic logic face_illegal(input logic [2:0] face);
    return (face < FACE_MIN) || (face > FACE_MAX);
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/saikoro_lfsr.sv
// Free-running 8-bit Fibonacci LFSR that supplies the spin-length jitter.
// Only instantiated when SAIKORO_ROLL_JITTER_EN is defined.
module saikoro_lfsr
  import saikoro_pkg::*;
(
  input  logic       ck,
  input  logic       reset,
  output logic [7:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same edge, independent of statement order.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) q <= LFSR_SEED;
    else        q <= lfsr_next(q);
  end

endmodule

// File: rtl/saikoro_roll_ctrl.sv
// Roll sequencer: turns a start request into fast-spin, decelerating and
// settle phases of dice_en, then latches the face and rotates the player.
// Optional spin-length jitter is enabled by defining SAIKORO_ROLL_JITTER_EN.
module saikoro_roll_ctrl
  import saikoro_pkg::*;
#(
  parameter  int FAST_CYC   = 16,
  parameter  int SLOW_STEPS = 6,
  parameter  int GAP_INC    = 2,
  parameter  int NPLAYER    = 2,
  localparam int PW         = (NPLAYER > 1) ? $clog2(NPLAYER) : 1
) (
  input  logic          ck,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    face_in,
  output logic          dice_en,
  output logic          busy,
  output logic          done,
  output logic [2:0]    result,
  output logic          err,
  output logic [PW-1:0] player
);

`ifdef SAIKORO_ROLL_JITTER_EN
  localparam int SPIN_MAX = FAST_CYC + 7;
`else
  localparam int SPIN_MAX = FAST_CYC;
`endif
  localparam int SCW = $clog2(SPIN_MAX + 1);
  localparam int GW  = $clog2(GAP_INC * SLOW_STEPS + 1);
  localparam int STW = (SLOW_STEPS > 1) ? $clog2(SLOW_STEPS) : 1;

  state_t           state, next_state;
  logic [SCW-1:0]   spin_cnt;
  logic [SCW-1:0]   spin_last;
  logic [GW-1:0]    gap_cnt;
  logic [GW-1:0]    gap_target;
  logic [STW-1:0]   step;
  logic             spin_end;
  logic             pulse;
  logic             last_step;

`ifdef SAIKORO_ROLL_JITTER_EN
  logic [7:0] lfsr_q;
  logic [2:0] jitter;

  saikoro_lfsr u_lfsr (
    .ck    (ck),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign jitter = lfsr_q[2:0];

  // Spin length is frozen at the IDLE->SPIN edge so the LFSR can keep running.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset)                      spin_last <= SCW'(FAST_CYC - 1);
    else if (state == IDLE && start) spin_last <= SCW'(FAST_CYC - 1) + SCW'(jitter);
  end
`else
  assign spin_last = SCW'(FAST_CYC - 1);
`endif

  // Low gap before slow pulse k is GAP_INC*(k+1); the pulse fires when it is reached.
  assign gap_target = GW'(GAP_INC * (int'(step) + 1));
  assign spin_end   = (state == SPIN) && (spin_cnt == spin_last);
  assign pulse      = (state == SLOW) && (gap_cnt == gap_target);
  assign last_step  = (step == STW'(SLOW_STEPS - 1));

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    dice_en    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = SPIN;
      end
      SPIN: begin
        dice_en = 1'b1;
        if (spin_end) next_state = SLOW;
      end
      SLOW: begin
        dice_en = pulse;
        if (pulse && last_step) next_state = SETTLE;
      end
      SETTLE: next_state = DONE;
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      spin_cnt <= '0;
      gap_cnt  <= '0;
      step     <= '0;
    end else begin
      unique case (state)
        IDLE: spin_cnt <= '0;
        SPIN: begin
          spin_cnt <= spin_cnt + 1'b1;
          gap_cnt  <= '0;
          step     <= '0;
        end
        SLOW: begin
          if (pulse) begin
            gap_cnt <= '0;
            if (!last_step) step <= step + 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result and error flag are captured together at the end of the settle cycle.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      result <= '0;
      err    <= 1'b0;
    end else if (state == SETTLE) begin
      result <= face_in;
      err    <= face_illegal(face_in);
    end
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      player <= '0;
    end else if (state == DONE) begin
      if (player == PW'(NPLAYER - 1)) player <= '0;
      else                            player <= player + 1'b1;
    end
  end

endmodule

// File: tb/tb_saikoro_roll_ctrl.sv
// Self-checking bench for saikoro_roll_ctrl: a behavioural dice counter
// plus a phase-list reference model of the dice_en timeline and roll results.
module tb_saikoro_roll_ctrl;

  localparam int FAST = 16;
  localparam int SLOW = 6;
  localparam int GAP  = 2;
  localparam int NP   = 2;

  typedef bit bq_t[$];

  logic       ck = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] face_in;
  logic       dice_en, busy, done, err;
  logic [2:0] result;
  logic [0:0] player;

  int compared   = 0;
  int mismatched = 0;

  logic [2:0] face_q;
  bit         force_en;
  logic [2:0] force_val;
  int         exp_player;
  bit         trace[$];
  int         last_j;

  saikoro_roll_ctrl #(
    .FAST_CYC   (FAST),
    .SLOW_STEPS (SLOW),
    .GAP_INC    (GAP),
    .NPLAYER    (NP)
  ) dut (
    .ck      (ck),
    .reset   (reset),
    .start   (start),
    .face_in (face_in),
    .dice_en (dice_en),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err),
    .player  (player)
  );

  always #5 ck = ~ck;

  // Behavioural dice counter: advances 1..6 on each enabled edge.
  always @(posedge ck) begin
    if (dice_en) face_q <= (face_q == 3'd6) ? 3'd1 : face_q + 3'd1;
  end

  assign face_in = force_en ? force_val : face_q;

`ifdef SAIKORO_ROLL_JITTER_EN
  logic [7:0] lfsr_m;
  always @(posedge ck or negedge reset) begin
    if (!reset) lfsr_m <= 8'h01;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end
  function automatic int cur_jitter();
    return int'(lfsr_m[2:0]);
  endfunction
`else
  function automatic int cur_jitter();
    return 0;
  endfunction
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // Expected dice_en per cycle after the start edge, through the done cycle.
  function automatic bq_t build_exp(input int j);
    bq_t q;
    q = {};
    for (int i = 0; i < FAST + j; i++) q.push_back(1'b1);
    for (int k = 0; k < SLOW; k++) begin
      for (int g = 0; g < GAP * (k + 1); g++) q.push_back(1'b0);
      q.push_back(1'b1);
    end
    q.push_back(1'b0);
    q.push_back(1'b0);
    return q;
  endfunction

  // Caller is in an IDLE cycle ("cycle 0"); returns in the IDLE cycle after DONE.
  task automatic run_roll(input bit hold, input bit poke, input bit do_force,
                          input logic [2:0] fval, input bit keep_start);
    bq_t  exp_en;
    int   j, lat, f0, exp_res;
    logic exp_err;
    j       = cur_jitter();
    last_j  = j;
    exp_en  = build_exp(j);
    lat     = exp_en.size();
    f0      = int'(face_q);
    exp_res = ((f0 - 1 + FAST + j + SLOW) % 6) + 1;
    if (do_force) exp_res = int'(fval);
    exp_err = (exp_res < 1) || (exp_res > 6);
    trace   = {};
    start   = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      tick();
      if (!hold) start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      force_en  = do_force && (c == lat - 1);
      force_val = fval;
      check($sformatf("dice_en_c%0d", c), dice_en, exp_en[c-1]);
      check($sformatf("busy_c%0d", c), busy, 1'b1);
      check($sformatf("done_c%0d", c), done, (c == lat));
      trace.push_back(dice_en);
    end
    tick();
    start    = keep_start;
    force_en = 1'b0;
    exp_player = (exp_player + 1) % NP;
    check("busy_after", busy, 1'b0);
    check("done_after", done, 1'b0);
    check("result", result, exp_res);
    check("err", err, exp_err);
    check("player", player, exp_player);
  endtask

  task automatic analyze();
    int idx, spin, z, pulses;
    idx = 0;
    spin = 0;
    while (idx < trace.size() && trace[idx]) begin
      spin++;
      idx++;
    end
    check("spin_len", spin, FAST + last_j);
    for (int k = 0; k < SLOW; k++) begin
      z = 0;
      while (idx < trace.size() && !trace[idx]) begin
        z++;
        idx++;
      end
      check($sformatf("gap_%0d", k), z, GAP * (k + 1));
      idx++;
    end
    pulses = 0;
    foreach (trace[i]) pulses += int'(trace[i]);
    check("pulse_count", pulses, FAST + last_j + SLOW);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      start = 1'b0;
      check("idle_busy", busy, 1'b0);
    end
  endtask

  // Start a roll, assert reset mid-cycle after 'at' cycles, then release.
  task automatic reset_mid(input int at);
    bq_t  exp_en;
    logic en_before, busy_before;
    exp_en = build_exp(cur_jitter());
    start  = 1'b1;
    for (int c = 1; c <= at; c++) begin
      tick();
      start = 1'b0;
    end
    #2;
    en_before   = dice_en;
    busy_before = busy;
    reset = 1'b0;
    #1;
    check("pre_rst_busy", busy_before, 1'b1);
    check("pre_rst_en", en_before, exp_en[at-1]);
    check("rst_dice_en", dice_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 3'd0);
    check("rst_err", err, 1'b0);
    check("rst_player", player, 1'b0);
    exp_player = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold_done", done, 1'b0);
      check("rst_hold_en", dice_en, 1'b0);
    end
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    force_en   = 1'b0;
    force_val  = 3'd0;
    face_q     = 3'd1;
    exp_player = 0;
    last_j     = 0;

    tick();
    tick();
    check("reset_dice_en", dice_en, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_result", result, 3'd0);
    check("reset_player", player, 1'b0);
    reset = 1'b1;

    // First roll from face 1, then phase/gap analysis of the observed trace.
    run_roll(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
`ifndef SAIKORO_ROLL_JITTER_EN
    check("first_result_5", result, 3'd5);
    check("first_player_1", player, 1'b1);
`endif
    analyze();

    // Back-to-back rolls with start held high the whole time.
    idle(2);
    run_roll(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    run_roll(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    analyze();

    // Randomised idle gaps, start pokes while busy, and optional forced faces.
    for (int r = 0; r < 4; r++) begin
      idle($urandom_range(0, 5));
      run_roll(1'b0, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0);
      analyze();
    end

    // Reset during the slow phase, then during spin, each followed by a clean roll.
    idle(1);
    reset_mid(30);
    run_roll(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(1);
    reset_mid($urandom_range(1, FAST));
    run_roll(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);

    // Out-of-range face captured in settle.
    idle(1);
    run_roll(1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
    check("forced_result_7", result, 3'd7);
    check("forced_err_1", err, 1'b1);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
